cpu_lsu: RTL and testbench

Load/store unit that sits on the memory side of the execute stage. It takes the ALU's effective address and the raw rt value, then runs one Avalon-MM style word transaction with big-endian byte-lane steering. It returns the load result aligned and extended, ready for register writeback. It owns the bus handshake (waitrequest stalls), byte enables, misalignment detection and an optional stall timeout.

---
 rtl/cpu_lsu_pkg.sv | 32 +++
 rtl/lsu_lane_align.sv | 64 ++++++
 rtl/cpu_lsu.sv | 159 +++++++++++++++
 tb/tb_cpu_lsu.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_lsu_pkg.sv
// Shared operation codes and classification helpers for the load/store unit.
package cpu_lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    typedef enum logic [2:0] {
        MEM_LW  = 3'd0,
        MEM_LH  = 3'd1,
        MEM_LHU = 3'd2,
        MEM_LB  = 3'd3,
        MEM_LBU = 3'd4,
        MEM_SW  = 3'd5,
        MEM_SH  = 3'd6,
        MEM_SB  = 3'd7
    } mem_op_t;

    // True for operations that drive write_o rather than read_o.
    function automatic logic is_store(input mem_op_t op);
        return (op == MEM_SW) || (op == MEM_SH) || (op == MEM_SB);
    endfunction

    // Words need a 4-byte boundary, halves a 2-byte boundary.
    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] off);
        case (op)
            MEM_LW, MEM_SW:          return off != 2'b00;
            MEM_LH, MEM_LHU, MEM_SH: return off[0];
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian byte-lane steering for stores and lane extraction/extension for loads.
module lsu_lane_align
    import cpu_lsu_pkg::*;
(
    input  mem_op_t            op,
    input  logic [1:0]         offset,
    input  logic [XLEN-1:0]    store_data,
    input  logic [XLEN-1:0]    readdata,
    output logic [BE_W-1:0]    byteenable,
    output logic [XLEN-1:0]    writedata,
    output logic [XLEN-1:0]    load_value
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Offset 0 is the most significant lane.
    always_comb begin
        case (offset)
            2'd0:    rd_byte = readdata[31:24];
            2'd1:    rd_byte = readdata[23:16];
            2'd2:    rd_byte = readdata[15:8];
            default: rd_byte = readdata[7:0];
        endcase
        rd_half = offset[1] ? readdata[15:0] : readdata[31:16];
    end

    // Lane enables, replicated store data and extended load value per op.
    always_comb begin
        byteenable = 4'b1111;
        writedata  = store_data;
        load_value = readdata;
        case (op)
            MEM_LB: begin
                byteenable = 4'b1000 >> offset;
                load_value = {{24{rd_byte[7]}}, rd_byte};
            end
            MEM_LBU: begin
                byteenable = 4'b1000 >> offset;
                load_value = {24'd0, rd_byte};
            end
            MEM_SB: begin
                byteenable = 4'b1000 >> offset;
                writedata  = {4{store_data[7:0]}};
            end
            MEM_LH: begin
                byteenable = offset[1] ? 4'b0011 : 4'b1100;
                load_value = {{16{rd_half[15]}}, rd_half};
            end
            MEM_LHU: begin
                byteenable = offset[1] ? 4'b0011 : 4'b1100;
                load_value = {16'd0, rd_half};
            end
            MEM_SH: begin
                byteenable = offset[1] ? 4'b0011 : 4'b1100;
                writedata  = {2{store_data[15:0]}};
            end
            default: begin
                byteenable = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/cpu_lsu.sv
// Load/store unit: one Avalon-MM word transaction per start, with stall timeout.
module cpu_lsu
    import cpu_lsu_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  mem_op_t            mem_op_i,
    input  logic [XLEN-1:0]    effective_address_i,
    input  logic [XLEN-1:0]    store_data_i,
    output logic [XLEN-1:0]    address_o,
    output logic               read_o,
    output logic               write_o,
    output logic [BE_W-1:0]    byteenable_o,
    output logic [XLEN-1:0]    writedata_o,
    input  logic               waitrequest_i,
    input  logic [XLEN-1:0]    readdata_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o,
    output logic [XLEN-1:0]    load_data_o
);

    localparam int unsigned CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state, state_d;
    mem_op_t          op_q, op_d;
    logic [1:0]       off_q, off_d;
    logic [CNT_W-1:0] wait_cnt, cnt_d;
    logic [CNT_W:0]   cnt_inc;

    logic [XLEN-1:0]  address_d, writedata_d, load_data_d;
    logic [BE_W-1:0]  byteenable_d;
    logic             read_d, write_d, busy_d, done_d, error_d;

    mem_op_t          al_op;
    logic [1:0]       al_off;
    logic [BE_W-1:0]  al_be;
    logic [XLEN-1:0]  al_wd, al_load;

    // In IDLE steer the incoming request; afterwards steer the latched one.
    assign al_op   = (state == ST_IDLE) ? mem_op_i : op_q;
    assign al_off  = (state == ST_IDLE) ? effective_address_i[1:0] : off_q;
    assign cnt_inc = {1'b0, wait_cnt} + (CNT_W + 1)'(1);

    lsu_lane_align u_align (
        .op         (al_op),
        .offset     (al_off),
        .store_data (store_data_i),
        .readdata   (readdata_i),
        .byteenable (al_be),
        .writedata  (al_wd),
        .load_value (al_load)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_d      = state;
        op_d         = op_q;
        off_d        = off_q;
        cnt_d        = wait_cnt;
        address_d    = address_o;
        read_d       = read_o;
        write_d      = write_o;
        byteenable_d = byteenable_o;
        writedata_d  = writedata_o;
        error_d      = error_o;
        load_data_d  = load_data_o;
        case (state)
            ST_IDLE: begin
                cnt_d   = '0;
                error_d = 1'b0;
                if (start_i) begin
                    op_d  = mem_op_i;
                    off_d = effective_address_i[1:0];
                    if (is_misaligned(mem_op_i, effective_address_i[1:0])) begin
                        state_d = ST_DONE;
                        error_d = 1'b1;
                    end else begin
                        state_d      = ST_REQ;
                        address_d    = {effective_address_i[XLEN-1:2], 2'b00};
                        byteenable_d = al_be;
                        writedata_d  = al_wd;
                        read_d       = !is_store(mem_op_i);
                        write_d      = is_store(mem_op_i);
                    end
                end
            end
            ST_REQ: begin
                if (!waitrequest_i) begin
                    state_d = ST_DONE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (!is_store(op_q)) begin
                        load_data_d = al_load;
                    end
                end else if ((WAIT_LIMIT > 0) && (cnt_inc == (CNT_W + 1)'(WAIT_LIMIT))) begin
                    state_d = ST_DONE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    error_d = 1'b1;
                end else begin
                    cnt_d = wait_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, counter and registered bus/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            op_q         <= MEM_LW;
            off_q        <= 2'b00;
            wait_cnt     <= '0;
            address_o    <= '0;
            read_o       <= 1'b0;
            write_o      <= 1'b0;
            byteenable_o <= '0;
            writedata_o  <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            load_data_o  <= '0;
        end else begin
            state        <= state_d;
            op_q         <= op_d;
            off_q        <= off_d;
            wait_cnt     <= cnt_d;
            address_o    <= address_d;
            read_o       <= read_d;
            write_o      <= write_d;
            byteenable_o <= byteenable_d;
            writedata_o  <= writedata_d;
            busy_o       <= busy_d;
            done_o       <= done_d;
            error_o      <= error_d;
            load_data_o  <= load_data_d;
        end
    end

endmodule

// File: tb/tb_cpu_lsu.sv
// Directed bench for cpu_lsu with a done-driven scoreboard monitor.
module tb_cpu_lsu;
    import cpu_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    mem_op_t     mem_op_i;
    logic [31:0] effective_address_i;
    logic [31:0] store_data_i;
    logic [31:0] address_o;
    logic        read_o;
    logic        write_o;
    logic [3:0]  byteenable_o;
    logic [31:0] writedata_o;
    logic        waitrequest_i;
    logic [31:0] readdata_i;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic [31:0] load_data_o;

    typedef struct {
        logic        err;
        logic [31:0] ld;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    cpu_lsu #(.WAIT_LIMIT(4)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start_i             (start_i),
        .mem_op_i            (mem_op_i),
        .effective_address_i (effective_address_i),
        .store_data_i        (store_data_i),
        .address_o           (address_o),
        .read_o              (read_o),
        .write_o             (write_o),
        .byteenable_o        (byteenable_o),
        .writedata_o         (writedata_o),
        .waitrequest_i       (waitrequest_i),
        .readdata_i          (readdata_i),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .error_o             (error_o),
        .load_data_o         (load_data_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every done pulse pops one expected response.
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done_o=1 expected no completion at %0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("mon_error_o", 32'(error_o), 32'(mon_e.err));
                chk("mon_load_data_o", load_data_o, mon_e.ld);
            end
        end
        if (read_o && write_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rw_exclusive: got read_o=1 write_o=1 expected at most one at %0t", $time);
        end
    end

    // One transaction: checks bus phase cycle by cycle; the monitor checks the result.
    task automatic do_txn(input string tag, input mem_op_t op, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] rd, input int waits,
                          input logic exp_err, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_ld);
        logic st;
        st = is_store(op);
        sb_q.push_back('{exp_err, exp_ld});
        @(negedge clk);
        start_i             = 1'b1;
        mem_op_i            = op;
        effective_address_i = addr;
        store_data_i        = sd;
        readdata_i          = rd;
        waitrequest_i       = (waits > 0);
        @(negedge clk);
        start_i = 1'b0;
        if (exp_err) begin
            chk({tag, "_read_o"}, 32'(read_o), 32'(0));
            chk({tag, "_write_o"}, 32'(write_o), 32'(0));
            chk({tag, "_done_o"}, 32'(done_o), 32'(1));
        end else begin
            for (int i = 0; i <= waits; i++) begin
                if (i > 0) @(negedge clk);
                chk({tag, "_read_o"}, 32'(read_o), 32'(!st));
                chk({tag, "_write_o"}, 32'(write_o), 32'(st));
                chk({tag, "_address_o"}, address_o, {addr[31:2], 2'b00});
                chk({tag, "_byteenable_o"}, 32'(byteenable_o), 32'(exp_be));
                if (st) chk({tag, "_writedata_o"}, writedata_o, exp_wd);
                chk({tag, "_done_early"}, 32'(done_o), 32'(0));
                waitrequest_i       = (i < waits);
                start_i             = 1'b1;
                mem_op_i            = MEM_SB;
                effective_address_i = 32'h0000_0ffc;
            end
            @(negedge clk);
            start_i = 1'b0;
            chk({tag, "_done_o"}, 32'(done_o), 32'(1));
            chk({tag, "_req_released"}, 32'({read_o, write_o}), 32'(0));
        end
        waitrequest_i = 1'b0;
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done_o), 32'(0));
        chk({tag, "_busy_after"}, 32'(busy_o), 32'(0));
    endtask

    initial begin
        rst_n               = 1'b0;
        start_i             = 1'b0;
        mem_op_i            = MEM_LW;
        effective_address_i = '0;
        store_data_i        = '0;
        waitrequest_i       = 1'b0;
        readdata_i          = '0;
        #3;
        chk("rst_busy_o", 32'(busy_o), 32'(0));
        chk("rst_done_o", 32'(done_o), 32'(0));
        chk("rst_error_o", 32'(error_o), 32'(0));
        chk("rst_rw", 32'({read_o, write_o}), 32'(0));
        chk("rst_address_o", address_o, 32'h0);
        chk("rst_byteenable_o", 32'(byteenable_o), 32'h0);
        chk("rst_load_data_o", load_data_o, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //      tag    op       addr          store data    readdata      w  err be       wdata         load result
        do_txn("lw",   MEM_LW,  32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 4'b1111, 32'h0,        32'hDEADBEEF);
        do_txn("lb",   MEM_LB,  32'h203, 32'h0,        32'h000000F0, 0, 0, 4'b0001, 32'h0,        32'hFFFFFFF0);
        do_txn("lbu",  MEM_LBU, 32'h203, 32'h0,        32'h000000F0, 0, 0, 4'b0001, 32'h0,        32'h000000F0);
        do_txn("sh",   MEM_SH,  32'h302, 32'h12345678, 32'h0,        3, 0, 4'b0011, 32'h56785678, 32'h000000F0);
        do_txn("lwmis",MEM_LW,  32'h101, 32'h0,        32'h11111111, 0, 1, 4'b0000, 32'h0,        32'h000000F0);
        do_txn("lh",   MEM_LH,  32'h102, 32'h0,        32'h12348001, 0, 0, 4'b0011, 32'h0,        32'hFFFF8001);
        do_txn("lhu",  MEM_LHU, 32'h100, 32'h0,        32'h80011234, 0, 0, 4'b1100, 32'h0,        32'h00008001);
        do_txn("sb",   MEM_SB,  32'h201, 32'h000000AB, 32'h0,        1, 0, 4'b0100, 32'hABABABAB, 32'h00008001);
        do_txn("sw",   MEM_SW,  32'h400, 32'hCAFEF00D, 32'h0,        0, 0, 4'b1111, 32'hCAFEF00D, 32'h00008001);
        do_txn("shmis",MEM_SH,  32'h301, 32'h0000BEEF, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h00008001);
        do_txn("lb0",  MEM_LB,  32'h200, 32'h0,        32'h80123456, 2, 0, 4'b1000, 32'h0,        32'hFFFFFF80);
        do_txn("lb1",  MEM_LB,  32'h201, 32'h0,        32'h007F0000, 0, 0, 4'b0100, 32'h0,        32'h0000007F);

        // Stall timeout: request held for exactly four cycles, then an error completion.
        sb_q.push_back('{1'b1, 32'h0000007F});
        @(negedge clk);
        start_i             = 1'b1;
        mem_op_i            = MEM_LW;
        effective_address_i = 32'h500;
        readdata_i          = 32'h55555555;
        waitrequest_i       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start_i = 1'b0;
            chk("to_read_held", 32'(read_o), 32'(1));
            chk("to_done_early", 32'(done_o), 32'(0));
        end
        @(negedge clk);
        chk("to_read_dropped", 32'(read_o), 32'(0));
        chk("to_done_o", 32'(done_o), 32'(1));
        @(negedge clk);
        chk("to_busy_after", 32'(busy_o), 32'(0));
        waitrequest_i = 1'b0;

        // Asynchronous reset in the middle of a stalled request.
        @(negedge clk);
        start_i             = 1'b1;
        mem_op_i            = MEM_LW;
        effective_address_i = 32'h600;
        waitrequest_i       = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("rr_read_before", 32'(read_o), 32'(1));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_read_o", 32'(read_o), 32'(0));
        chk("rr_busy_o", 32'(busy_o), 32'(0));
        chk("rr_done_o", 32'(done_o), 32'(0));
        chk("rr_load_data_o", load_data_o, 32'h0);
        @(negedge clk);
        waitrequest_i = 1'b0;
        rst_n         = 1'b1;
        do_txn("post", MEM_LW, 32'h104, 32'h0, 32'h0BADF00D, 0, 0, 4'b1111, 32'h0, 32'h0BADF00D);

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pending_done: got %0d outstanding expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
